lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive end of the 20-bit dither LFSR stream that drives the delta-sigma modulator.
- Self-synchronises to an incoming LFSR word stream, then predicts every subsequent word and flags and counts mismatches.
- Used in the modulator datapath to confirm the dither source is healthy, and in benches to replace file dumps with a pass/fail error count.

Parameters:
- WIDTH, 20: LFSR word width. Only 20 is supported.
- LOCK_CNT, 4: consecutive correct predictions needed in VERIFY to declare lock.
- LOSS_CNT, 8: consecutive mismatches in LOCKED that drop lock.
- CNT_W, 32: width of the error and word counters.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- valid_i, input, 1: lfsr_i carries a new word this cycle. One LFSR step separates consecutive valid words.
- lfsr_i, input, signed [WIDTH-1:0]: received LFSR word, the full state.
- clear_i, input, 1: synchronous clear of the counters only. State is untouched.
- locked_o, output, 1: high while in LOCKED.
- err_o, output, 1: one-cycle pulse, a mismatch was detected while LOCKED.
- err_count_o, output, [CNT_W-1:0]: saturating count of LOCKED mismatches.
- word_count_o, output, [CNT_W-1:0]: saturating count of valid words checked while LOCKED.
- state_o, output, [1:0]: 0 = SEARCH, 1 = VERIFY, 2 = LOCKED.

Behaviour:
- Reset (synchronous, active-high): state SEARCH, predictor register 0, match and miss counters 0. All outputs 0.
- LFSR step function, bit-exact with the generator:
  - next = {s[18:0], s[19]^s[16]}, i.e. polynomial x^20+x^17+1.
  - Period is 2^20-1. All-zero is illegal.
- Every comparison uses prediction = step(pred_reg). Registered outputs update the cycle after the valid word (latency 1). Cycles with valid_i=0 change nothing.
- SEARCH:
  - Valid nonzero word: pred_reg <= word, match_cnt <= 0, go to VERIFY.
  - Valid zero word: ignored, stay in SEARCH.
- VERIFY:
  - Valid word == prediction: pred_reg <= word, match_cnt++.
  - When match_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt <= 0.
  - Mismatch: reseed pred_reg <= word and clear match_cnt. A zero word sends the FSM back to SEARCH.
- LOCKED:
  - Every valid word: pred_reg <= prediction. The checker free-runs on its own sequence, never the received word, so an isolated bit error costs exactly one error.
  - word_count++.
  - Match: miss_cnt <= 0.
  - Mismatch: err_o=1, err_count++, miss_cnt++.
  - When miss_cnt reaches LOSS_CNT, go to SEARCH. locked_o falls in the same cycle the LOSS_CNT-th err_o pulses.
- Counters saturate at all-ones and do not wrap.
- clear_i zeroes err_count and word_count.
  - If clear_i coincides with a counted event, clear wins and the counter reads 0.
  - err_o still pulses.
- reset asserted mid-lock: next cycle everything is at reset values, including counters.
- valid_i held low indefinitely: state and prediction hold. There is no timeout.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_W = 20 and tap constants (19, 16).
  - Function lfsr_step(), shared with the generator so both ends cannot diverge.
  - State encoding constants ST_SEARCH/ST_VERIFY/ST_LOCKED.
- One sub-module is natural: sat_counter (CNT_W-bit, inc/clear, saturating), instantiated twice.

Test Plan:
1. Lock: reset, then valid words 0x00001, 0x00002, 0x00004, 0x00008, 0x00010, 0x00020.
   - state_o goes 0→1 after the first word.
   - locked_o=1 the cycle after the 5th word (4 matches).
   - err_count_o=0, and word_count_o=1 after the 6th.
2. Feedback tap: locked stream reaching 0x10000.
   - Next expected word 0x20001 gives no err_o.
   - Driving 0x20000 instead gives err_o=1 once and err_count_o=1.
   - The following correct word 0x40002 gives no error, confirming free-running prediction.
3. Loss of lock: after lock, drive 8 consecutive wrong words.
   - 8 err_o pulses, err_count_o=8.
   - locked_o falls with the 8th pulse and state_o=0.
   - 7 wrong words followed by 1 correct word keeps lock.
4. Zero/search: in SEARCH drive 0x00000 ×3, then 0x00001.
   - Stays SEARCH for the zeros, VERIFY after 0x00001.
   - A mismatch in VERIFY reseeds and match_cnt restarts, so lock needs 4 further matches.
5. Counters: clear_i together with a mismatch gives err_count_o=0. Force near-saturation (CNT_W=4 build) and check counters stick at 15.
6. Reset mid-lock, plus gaps:
   - Assert reset while locked: next cycle locked_o=0, state_o=0, counters 0.
   - Separately, valid_i gaps of 1–10 cycles between locked words produce no errors.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 20-bit dither LFSR, used by both the generator
// and the receive-side checker so the two ends cannot diverge.
//   LFSR_W      : word width of the dither LFSR
//   TAP_HI/LO   : feedback taps for polynomial x^20 + x^17 + 1
//   lfsr_step() : one shift of the generator
//   ST_*        : checker state encoding as seen on state_o
package lfsr_pkg;

  localparam int LFSR_W = 20;
  localparam int TAP_HI = 19;
  localparam int TAP_LO = 16;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    S_SEARCH = ST_SEARCH,
    S_VERIFY = ST_VERIFY,
    S_LOCKED = ST_LOCKED
  } chk_state_t;

  // Shift left, feed s[19]^s[16] into bit 0. Period 2^20-1; zero is a lock-up state.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Bundles the word stream and status signals of the LFSR checker.
//   valid_i/lfsr_i : received LFSR word and its strobe
//   clear_i        : zero the error and word counters
//   locked_o, err_o, err_count_o, word_count_o, state_o : checker status
// master drives the stream (source/bench), slave is the checker.
interface lfsr_checker_if #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 32
);
  logic                    valid_i;
  logic signed [WIDTH-1:0] lfsr_i;
  logic                    clear_i;
  logic                    locked_o;
  logic                    err_o;
  logic [CNT_W-1:0]        err_count_o;
  logic [CNT_W-1:0]        word_count_o;
  logic [1:0]              state_o;

  modport master (
    output valid_i, lfsr_i, clear_i,
    input  locked_o, err_o, err_count_o, word_count_o, state_o
  );

  modport slave (
    input  valid_i, lfsr_i, clear_i,
    output locked_o, err_o, err_count_o, word_count_o, state_o
  );
endinterface

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock, reset : clock and synchronous active-high reset
//   inc          : count one event this cycle
//   clear        : zero the count; takes priority over inc
//   count_o      : current count, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count_o = count_reg;
endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 20-bit dither LFSR stream. Synchronises to the
// incoming words (SEARCH -> VERIFY -> LOCKED), then free-runs its own
// predictor and flags/counts every word that disagrees.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : valid_i/lfsr_i/clear_i in; locked_o, err_o, err_count_o,
//                  word_count_o, state_o out. All outputs are registered and
//                  reflect a valid word one cycle after it is presented.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 8,
  parameter int CNT_W    = 32
) (
  input  logic          clock,
  input  logic          reset,
  lfsr_checker_if.slave bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(LOSS_CNT + 1);

  chk_state_t        state_reg;
  logic [WIDTH-1:0]  pred_reg;
  logic [MW-1:0]     match_reg;
  logic [SW-1:0]     miss_reg;
  logic              err_reg;
  logic              locked_reg;

  logic [WIDTH-1:0]  word;
  logic [WIDTH-1:0]  prediction;
  logic              hit;

  assign word       = $unsigned(bus.lfsr_i);
  assign prediction = lfsr_step(pred_reg);
  assign hit        = (word == prediction);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_SEARCH;
      pred_reg   <= '0;
      match_reg  <= '0;
      miss_reg   <= '0;
      err_reg    <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (bus.valid_i) begin
        case (state_reg)
          S_SEARCH: begin
            // Zero is the LFSR lock-up state and can never be a seed.
            if (word != '0) begin
              pred_reg  <= word;
              match_reg <= '0;
              state_reg <= S_VERIFY;
            end
          end
          S_VERIFY: begin
            pred_reg <= word;
            if (hit) begin
              if (match_reg == MW'(LOCK_CNT - 1)) begin
                state_reg  <= S_LOCKED;
                locked_reg <= 1'b1;
                match_reg  <= '0;
                miss_reg   <= '0;
              end else begin
                match_reg <= match_reg + 1'b1;
              end
            end else begin
              // Reseed from the received word and start counting again.
              match_reg <= '0;
              if (word == '0) begin
                state_reg <= S_SEARCH;
              end
            end
          end
          S_LOCKED: begin
            // Free-run on our own sequence so one corrupted word costs one error.
            pred_reg <= prediction;
            if (hit) begin
              miss_reg <= '0;
            end else begin
              err_reg <= 1'b1;
              if (miss_reg == SW'(LOSS_CNT - 1)) begin
                state_reg  <= S_SEARCH;
                locked_reg <= 1'b0;
                miss_reg   <= '0;
              end else begin
                miss_reg <= miss_reg + 1'b1;
              end
            end
          end
          default: begin
            state_reg  <= S_SEARCH;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // Counter 0 counts LOCKED mismatches, counter 1 counts LOCKED words.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = bus.valid_i && (state_reg == S_LOCKED) && !hit;
  assign cnt_inc[1] = bus.valid_i && (state_reg == S_LOCKED);

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc     (cnt_inc[gi]),
      .clear   (bus.clear_i),
      .count_o (cnt_val[gi])
    );
  end

  assign bus.locked_o     = locked_reg;
  assign bus.err_o        = err_reg;
  assign bus.err_count_o  = cnt_val[0];
  assign bus.word_count_o = cnt_val[1];
  assign bus.state_o      = state_reg;
endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lfsr_checker_if #(.WIDTH(20), .CNT_W(32)) bus  ();
  lfsr_checker_if #(.WIDTH(20), .CNT_W(4))  bus4 ();

  // Narrow-counter instance sees exactly the same stream.
  assign bus4.valid_i = bus.valid_i;
  assign bus4.lfsr_i  = bus.lfsr_i;
  assign bus4.clear_i = bus.clear_i;

  lfsr_checker #(.WIDTH(20), .LOCK_CNT(4), .LOSS_CNT(8), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  lfsr_checker #(.WIDTH(20), .LOCK_CNT(4), .LOSS_CNT(8), .CNT_W(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    bit     locked;
    bit     err;
    int     state;
    longint errc;
    longint wordc;
    string  tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: plain integers following the checker's rules.
  int     m_state = 0;   // 0 search, 1 verify, 2 locked
  int     m_pred  = 0;
  int     m_match = 0;
  int     m_miss  = 0;
  longint m_errc  = 0;
  longint m_wordc = 0;
  int     gen     = 1;   // generator's current word
  string  phase   = "init";

  function automatic int nxt(int s);
    return ((s * 2) & 32'hFFFFF) | (((s >> 19) ^ (s >> 16)) & 1);
  endfunction

  function automatic longint sat(longint v, longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic drive(bit v, int w, bit clr, bit rst);
    exp_t x;
    int   p;
    bit   e;
    int   wv;
    @(negedge clock);
    wv          = w & 32'hFFFFF;
    reset       = rst;
    bus.valid_i = v;
    bus.lfsr_i  = wv[19:0];
    bus.clear_i = clr;
    e = 1'b0;
    if (rst) begin
      m_state = 0; m_pred = 0; m_match = 0; m_miss = 0; m_errc = 0; m_wordc = 0;
    end else begin
      if (v) begin
        p = nxt(m_pred);
        if (m_state == 0) begin
          if (wv != 0) begin
            m_pred = wv; m_match = 0; m_state = 1;
          end
        end else if (m_state == 1) begin
          if (wv == p) begin
            m_pred = wv;
            m_match++;
            if (m_match == 4) begin
              m_state = 2; m_miss = 0;
            end
          end else begin
            m_pred = wv; m_match = 0;
            if (wv == 0) m_state = 0;
          end
        end else begin
          m_pred = p;
          m_wordc++;
          if (wv == p) begin
            m_miss = 0;
          end else begin
            e = 1'b1;
            m_errc++;
            m_miss++;
            if (m_miss == 8) m_state = 0;
          end
        end
      end
      if (clr) begin
        m_errc = 0; m_wordc = 0;
      end
    end
    x.locked = (m_state == 2);
    x.err    = e;
    x.state  = m_state;
    x.errc   = m_errc;
    x.wordc  = m_wordc;
    x.tag    = phase;
    sb.push_back(x);
  endtask

  task automatic good();
    gen = nxt(gen);
    drive(1'b1, gen, 1'b0, 1'b0);
  endtask

  task automatic bad();
    int w;
    gen = nxt(gen);
    w   = gen ^ int'($urandom_range(1, 32'hFFFFF));
    drive(1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic chk(string tag, string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s %s: got %0d required %0d (cycle %0d)", tag, name, act, req, cyc);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk(x.tag, "state_o",       longint'(bus.state_o),      longint'(x.state));
        chk(x.tag, "locked_o",      longint'(bus.locked_o),     longint'(x.locked));
        chk(x.tag, "err_o",         longint'(bus.err_o),        longint'(x.err));
        chk(x.tag, "err_count_o",   longint'(bus.err_count_o),  sat(x.errc, 64'hFFFFFFFF));
        chk(x.tag, "word_count_o",  longint'(bus.word_count_o), sat(x.wordc, 64'hFFFFFFFF));
        chk(x.tag, "w4 locked_o",   longint'(bus4.locked_o),    longint'(x.locked));
        chk(x.tag, "w4 err_count",  longint'(bus4.err_count_o), sat(x.errc, 15));
        chk(x.tag, "w4 word_count", longint'(bus4.word_count_o), sat(x.wordc, 15));
        $display("cyc %0d %s: v=%0b w=%05h clr=%0b rst=%0b -> st=%0d lk=%0b err=%0b ec=%0d wc=%0d",
                 cyc, x.tag, bus.valid_i, bus.lfsr_i, bus.clear_i, reset,
                 bus.state_o, bus.locked_o, bus.err_o, bus.err_count_o, bus.word_count_o);
      end
    end
  end

  initial begin : stimulus
    int w;
    int r;
    bus.valid_i = 1'b0;
    bus.lfsr_i  = '0;
    bus.clear_i = 1'b0;

    phase = "reset";
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1);

    // Lock on 1,2,4,8,16,32 and run through the feedback tap cleanly.
    phase = "lock";
    gen = 1;
    drive(1'b1, gen, 1'b0, 1'b0);
    repeat (5) good();
    while (gen != 32'h10000) good();
    good();   // 0x20001
    good();   // 0x40002

    // Same stream, but corrupt the first word that depends on the tap.
    phase = "tap";
    drive(1'b0, 0, 1'b0, 1'b1);
    gen = 1;
    drive(1'b1, gen, 1'b0, 1'b0);
    while (gen != 32'h10000) good();
    gen = nxt(gen);
    drive(1'b1, 32'h20000, 1'b0, 1'b0);
    good();   // 0x40002 must still match

    // Seven misses then a hit keeps lock; eight in a row drops it.
    phase = "loss";
    repeat (7) bad();
    good();
    repeat (8) bad();

    // Zeros are ignored in SEARCH; a VERIFY miss restarts the match count.
    phase = "search";
    repeat (3) drive(1'b1, 0, 1'b0, 1'b0);
    gen = 1;
    drive(1'b1, gen, 1'b0, 1'b0);
    repeat (2) good();
    do w = nxt(gen) ^ int'($urandom_range(1, 32'hFFFFF)); while (w == 0);
    gen = w;
    drive(1'b1, gen, 1'b0, 1'b0);
    repeat (4) good();

    // Push both counters past 15, then clear on a mismatch.
    phase = "counters";
    repeat (20) begin bad(); good(); end
    gen = nxt(gen);
    drive(1'b1, gen ^ 32'h00100, 1'b1, 1'b0);
    repeat (3) good();

    // Idle gaps while locked, then reset in the middle of lock.
    phase = "gaps";
    repeat (20) begin
      idle($urandom_range(1, 10));
      good();
    end
    phase = "rst_mid";
    drive(1'b0, 0, 1'b0, 1'b1);
    idle(2);

    // Random mixture of traffic.
    phase = "random";
    do gen = int'($urandom_range(1, 32'hFFFFF)); while (gen == 0);
    drive(1'b1, gen, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 199);
      if (r < 110)       good();
      else if (r < 140)  bad();
      else if (r < 160)  idle(1);
      else if (r < 172)  begin gen = nxt(gen); drive(1'b1, gen, 1'b1, 1'b0); end
      else if (r < 180)  drive(1'b1, 0, 1'b0, 1'b0);
      else if (r < 194)  begin
        do gen = int'($urandom_range(1, 32'hFFFFF)); while (gen == 0);
        drive(1'b1, gen, 1'b0, 1'b0);
      end
      else if (r < 196)  drive(1'b0, 0, 1'b0, 1'b1);
      else               drive(1'b1, gen, 1'b1, 1'b0);
    end

    @(negedge clock);
    bus.valid_i = 1'b0;
    bus.clear_i = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
